// File: rtl/id_stage.sv
// Instruction-decode stage of a 5-stage MIPS pipeline: decode, register file read/write,
// load-use hazard detection and the ID/EX pipeline register.
module id_stage #(
    parameter int unsigned DATA_W    = 32,
    parameter bit          BYPASS_WB = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_id_valid,
    input  logic [31:0]       npc_in,
    input  logic [31:0]       instr_in,
    input  logic              flush,
    input  logic              wb_regwrite,
    input  logic [4:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              id_ex_valid,
    output logic [1:0]        ctl_wb,
    output logic [2:0]        ctl_m,
    output logic [3:0]        ctl_ex,
    output logic [31:0]       npc_out,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [31:0]       imm_ext,
    output logic [4:0]        rt_out,
    output logic [4:0]        rd_out,
    output logic              illegal
);

    localparam int unsigned NREGS = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    logic [5:0]        opcode;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [31:0]       imm_sx;

    assign opcode = instr_in[31:26];
    assign rs     = instr_in[25:21];
    assign rt     = instr_in[20:16];
    assign rd     = instr_in[15:11];
    assign imm_sx = {{16{instr_in[15]}}, instr_in[15:0]};

    // Main control decode
    logic [1:0] dec_wb;
    logic [2:0] dec_m;
    logic [3:0] dec_ex;
    logic       dec_illegal;

    always_comb begin
        dec_wb      = 2'b00;
        dec_m       = 3'b000;
        dec_ex      = 4'b0000;
        dec_illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec_ex = 4'b1100;
                dec_wb = 2'b10;
            end
            OP_LW: begin
                dec_ex = 4'b0001;
                dec_m  = 3'b010;
                dec_wb = 2'b11;
            end
            OP_SW: begin
                dec_ex = 4'b0001;
                dec_m  = 3'b001;
            end
            OP_BEQ: begin
                dec_ex = 4'b0010;
                dec_m  = 3'b100;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Register file; r0 is never written and always reads zero
    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (wb_regwrite && (wb_rd != '0)) begin
            regs[wb_rd] <= wb_data;
        end
    end

    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;

    // Read ports with optional write-through of the same-cycle writeback
    always_comb begin
        rs_data = regs[rs];
        rt_data = regs[rt];
        if (BYPASS_WB && wb_regwrite && (wb_rd == rs)) begin
            rs_data = wb_data;
        end
        if (BYPASS_WB && wb_regwrite && (wb_rd == rt)) begin
            rt_data = wb_data;
        end
        if (rs == '0) begin
            rs_data = '0;
        end
        if (rt == '0) begin
            rt_data = '0;
        end
    end

    // Load-use: a load in EX whose destination matches either source here
    logic load_in_ex;
    logic rt_match;

    assign load_in_ex = id_ex_valid & ctl_m[1];
    assign rt_match   = (rt_out == rs) | (rt_out == rt);
    assign stall      = if_id_valid & load_in_ex & rt_match & ~flush;

    logic bubble;
    assign bubble = flush | stall | ~if_id_valid;

    // ID/EX pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_valid <= 1'b0;
            ctl_wb      <= 2'b00;
            ctl_m       <= 3'b000;
            ctl_ex      <= 4'b0000;
            npc_out     <= 32'h0;
            rd1         <= '0;
            rd2         <= '0;
            imm_ext     <= 32'h0;
            rt_out      <= '0;
            rd_out      <= '0;
            illegal     <= 1'b0;
        end else if (bubble) begin
            id_ex_valid <= 1'b0;
            ctl_wb      <= 2'b00;
            ctl_m       <= 3'b000;
            ctl_ex      <= 4'b0000;
            npc_out     <= 32'h0;
            rd1         <= '0;
            rd2         <= '0;
            imm_ext     <= 32'h0;
            rt_out      <= '0;
            rd_out      <= '0;
            illegal     <= 1'b0;
        end else begin
            id_ex_valid <= 1'b1;
            ctl_wb      <= dec_wb;
            ctl_m       <= dec_m;
            ctl_ex      <= dec_ex;
            npc_out     <= npc_in;
            rd1         <= rs_data;
            rd2         <= rt_data;
            imm_ext     <= imm_sx;
            rt_out      <= rt;
            rd_out      <= rd;
            illegal     <= dec_illegal;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Testbench for id_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_id_valid;
    logic [31:0] npc_in;
    logic [31:0] instr_in;
    logic        flush;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic        stall, id_ex_valid, illegal;
    logic [1:0]  ctl_wb;
    logic [2:0]  ctl_m;
    logic [3:0]  ctl_ex;
    logic [31:0] npc_out, rd1, rd2, imm_ext;
    logic [4:0]  rt_out, rd_out;

    logic        nb_stall, nb_valid, nb_illegal;
    logic [1:0]  nb_ctl_wb;
    logic [2:0]  nb_ctl_m;
    logic [3:0]  nb_ctl_ex;
    logic [31:0] nb_npc_out, nb_rd1, nb_rd2, nb_imm_ext;
    logic [4:0]  nb_rt_out, nb_rd_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_stage #(.DATA_W(32), .BYPASS_WB(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .if_id_valid(if_id_valid), .npc_in(npc_in),
        .instr_in(instr_in), .flush(flush), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .wb_data(wb_data), .stall(stall), .id_ex_valid(id_ex_valid), .ctl_wb(ctl_wb),
        .ctl_m(ctl_m), .ctl_ex(ctl_ex), .npc_out(npc_out), .rd1(rd1), .rd2(rd2),
        .imm_ext(imm_ext), .rt_out(rt_out), .rd_out(rd_out), .illegal(illegal)
    );

    id_stage #(.DATA_W(32), .BYPASS_WB(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .if_id_valid(if_id_valid), .npc_in(npc_in),
        .instr_in(instr_in), .flush(flush), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .wb_data(wb_data), .stall(nb_stall), .id_ex_valid(nb_valid), .ctl_wb(nb_ctl_wb),
        .ctl_m(nb_ctl_m), .ctl_ex(nb_ctl_ex), .npc_out(nb_npc_out), .rd1(nb_rd1), .rd2(nb_rd2),
        .imm_ext(nb_imm_ext), .rt_out(nb_rt_out), .rd_out(nb_rd_out), .illegal(nb_illegal)
    );

    // Behavioural model: architectural registers plus the expected ID/EX contents
    logic [31:0] mreg [32];
    logic        e_valid, e_ill;
    logic [8:0]  e_ctl;
    logic [31:0] e_npc, e_rd1, e_rd2, e_imm;
    logic [4:0]  e_rt, e_rd;

    // Control word {RegDst,ALUOp[1:0],ALUSrc,Branch,MemRead,MemWrite,RegWrite,MemtoReg}, illegal on top
    function automatic logic [9:0] mdecode(input logic [5:0] op);
        case (op)
            6'h00:   return {1'b0, 9'b110000010};
            6'h23:   return {1'b0, 9'b000101011};
            6'h2B:   return {1'b0, 9'b000100100};
            6'h04:   return {1'b0, 9'b001010000};
            default: return {1'b1, 9'b000000000};
        endcase
    endfunction

    function automatic logic [31:0] mread(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (wb_regwrite && wb_rd == a) return wb_data;
        return mreg[a];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        if_id_valid = 1'b0;
        npc_in      = 32'h0;
        instr_in    = 32'h0;
        flush       = 1'b0;
        wb_regwrite = 1'b0;
        wb_rd       = 5'd0;
        wb_data     = 32'h0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        logic [31:0] ins;
        do_reset();
        wb_regwrite = 1'b1; wb_rd = 5'd9; wb_data = 32'h0000_0055;
        step();
        drive_idle();
        if_id_valid = 1'b1; instr_in = 32'h8C22_0004; npc_in = 32'h0000_0104;
        step();
        instr_in = 32'h0043_2020; npc_in = 32'h0000_0108;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL reset_pre_stall: got %b want 1", stall);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({id_ex_valid, ctl_wb, ctl_m, ctl_ex, npc_out, rd1, rd2, imm_ext, rt_out, rd_out, illegal} !== '0) begin
            errors++;
            $display("FAIL reset_async_outputs: valid=%b wb=%b m=%b ex=%b npc=%h rd1=%h rd2=%h imm=%h rt=%0d rd=%0d ill=%b want all 0",
                     id_ex_valid, ctl_wb, ctl_m, ctl_ex, npc_out, rd1, rd2, imm_ext, rt_out, rd_out, illegal);
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall_drop: got %b want 0", stall);
        end
        drive_idle();
        step();
        rst_n = 1'b1;
        for (int i = 1; i < 32; i++) begin
            ins = {6'h00, 5'(i), 5'(i), 5'd1, 5'd0, 6'h20};
            if_id_valid = 1'b1; instr_in = ins;
            step();
            checks++;
            if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
                errors++; $display("FAIL reset_reg_r%0d: rd1=%h rd2=%h want 0", i, rd1, rd2);
            end
        end
        drive_idle();
        step();
    endtask

    task automatic test_wb_decode();
        wb_regwrite = 1'b1; wb_rd = 5'd5; wb_data = 32'h0000_00AA;
        step();
        drive_idle();
        if_id_valid = 1'b1; instr_in = 32'h00A5_1820; npc_in = 32'h0000_0200;
        step();
        checks++;
        if ({id_ex_valid, rd1, rd2, ctl_ex, ctl_wb, ctl_m, rd_out, npc_out} !==
            {1'b1, 32'hAA, 32'hAA, 4'b1100, 2'b10, 3'b000, 5'd3, 32'h0000_0200}) begin
            errors++;
            $display("FAIL wb_decode: valid=%b rd1=%h rd2=%h ex=%b wb=%b m=%b rd=%0d npc=%h want 1 aa aa 1100 10 000 3 200",
                     id_ex_valid, rd1, rd2, ctl_ex, ctl_wb, ctl_m, rd_out, npc_out);
        end
        drive_idle();
        step();
    endtask

    task automatic test_bypass();
        if_id_valid = 1'b1; instr_in = {6'h00, 5'd7, 5'd7, 5'd8, 5'd0, 6'h20};
        wb_regwrite = 1'b1; wb_rd = 5'd7; wb_data = 32'h0000_1234;
        step();
        checks++;
        if (rd1 !== 32'h1234 || rd2 !== 32'h1234) begin
            errors++; $display("FAIL bypass_on: rd1=%h rd2=%h want 1234", rd1, rd2);
        end
        checks++;
        if (nb_rd1 !== 32'h0) begin
            errors++; $display("FAIL bypass_off: rd1=%h want 0", nb_rd1);
        end
        wb_regwrite = 1'b0;
        step();
        checks++;
        if (nb_rd1 !== 32'h1234) begin
            errors++; $display("FAIL bypass_off_after: rd1=%h want 1234", nb_rd1);
        end
        drive_idle();
        step();
    endtask

    task automatic test_load_use();
        if_id_valid = 1'b1; instr_in = 32'h8C22_0004; npc_in = 32'h0000_0300;
        step();
        instr_in = 32'h0043_2020; npc_in = 32'h0000_0304;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL load_use_stall: got %b want 1", stall);
        end
        step();
        checks++;
        if ({id_ex_valid, ctl_wb, ctl_m, ctl_ex, illegal} !== '0) begin
            errors++; $display("FAIL load_use_bubble: valid=%b wb=%b m=%b ex=%b want 0", id_ex_valid, ctl_wb, ctl_m, ctl_ex);
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL load_use_one_cycle: got %b want 0", stall);
        end
        step();
        checks++;
        if ({id_ex_valid, ctl_ex, rd_out, npc_out} !== {1'b1, 4'b1100, 5'd4, 32'h0000_0304}) begin
            errors++; $display("FAIL load_use_issue: valid=%b ex=%b rd=%0d npc=%h want 1 1100 4 304", id_ex_valid, ctl_ex, rd_out, npc_out);
        end
        drive_idle();
        step();
    endtask

    task automatic test_flush_stall();
        if_id_valid = 1'b1; instr_in = 32'h8C22_0004; npc_in = 32'h0000_0400;
        step();
        instr_in = 32'h0043_2020; npc_in = 32'h0000_0404; flush = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL flush_stall_comb: got %b want 0", stall);
        end
        step();
        checks++;
        if ({id_ex_valid, ctl_wb, ctl_m, ctl_ex, illegal} !== '0) begin
            errors++; $display("FAIL flush_bubble: valid=%b wb=%b m=%b ex=%b want 0", id_ex_valid, ctl_wb, ctl_m, ctl_ex);
        end
        flush = 1'b0; instr_in = 32'hAC65_0008; npc_in = 32'h0000_0500;
        step();
        checks++;
        if ({id_ex_valid, ctl_m, ctl_ex, npc_out, imm_ext} !== {1'b1, 3'b001, 4'b0001, 32'h0000_0500, 32'h8}) begin
            errors++; $display("FAIL flush_no_repeat: valid=%b m=%b ex=%b npc=%h imm=%h want 1 001 0001 500 8",
                               id_ex_valid, ctl_m, ctl_ex, npc_out, imm_ext);
        end
        drive_idle();
        step();
    endtask

    task automatic test_signext_illegal();
        if_id_valid = 1'b1; instr_in = 32'h8C22_FFFC;
        step();
        checks++;
        if ({imm_ext, ctl_wb, ctl_m, ctl_ex, illegal} !== {32'hFFFF_FFFC, 2'b11, 3'b010, 4'b0001, 1'b0}) begin
            errors++; $display("FAIL signext: imm=%h wb=%b m=%b ex=%b ill=%b want fffffffc 11 010 0001 0", imm_ext, ctl_wb, ctl_m, ctl_ex, illegal);
        end
        if_id_valid = 1'b0;
        step();
        if_id_valid = 1'b1; instr_in = 32'hFC00_0000;
        step();
        checks++;
        if ({id_ex_valid, illegal, ctl_wb, ctl_m, ctl_ex} !== {1'b1, 1'b1, 9'b0}) begin
            errors++; $display("FAIL illegal_op: valid=%b ill=%b wb=%b m=%b ex=%b want 1 1 0 0 0", id_ex_valid, illegal, ctl_wb, ctl_m, ctl_ex);
        end
        if_id_valid = 1'b1; instr_in = {6'h00, 5'd0, 5'd0, 5'd1, 5'd0, 6'h20};
        wb_regwrite = 1'b1; wb_rd = 5'd0; wb_data = 32'h0000_DEAD;
        step();
        checks++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
            errors++; $display("FAIL r0_bypass: rd1=%h rd2=%h want 0", rd1, rd2);
        end
        wb_regwrite = 1'b0;
        step();
        checks++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
            errors++; $display("FAIL r0_write: rd1=%h rd2=%h want 0", rd1, rd2);
        end
        drive_idle();
        step();
    endtask

    task automatic test_random();
        logic        hold, e_stall;
        logic [5:0]  op;
        logic [4:0]  rs, rt;
        logic [9:0]  dec;
        logic        n_valid, n_ill;
        logic [8:0]  n_ctl;
        logic [31:0] n_npc, n_rd1, n_rd2, n_imm;
        logic [4:0]  n_rt, n_rd;
        do_reset();
        for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
        e_valid = 1'b0; e_ill = 1'b0; e_ctl = '0;
        e_npc = '0; e_rd1 = '0; e_rd2 = '0; e_imm = '0; e_rt = '0; e_rd = '0;
        hold = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!hold) begin
                if_id_valid = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 4))
                    0: op = 6'h00;
                    1: op = 6'h23;
                    2: op = 6'h2B;
                    3: op = 6'h04;
                    default: op = 6'($urandom_range(0, 63));
                endcase
                instr_in = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
                npc_in = $urandom;
            end
            flush       = ($urandom_range(0, 9) == 0);
            wb_regwrite = 1'($urandom_range(0, 1));
            wb_rd       = 5'($urandom_range(0, 7));
            wb_data     = $urandom;
            #1;
            rs = instr_in[25:21];
            rt = instr_in[20:16];
            e_stall = if_id_valid && e_valid && e_ctl[3] && (e_rt == rs || e_rt == rt) && !flush;
            checks++;
            if (stall !== e_stall) begin
                errors++; $display("FAIL rand_stall cyc %0d: got %b want %b", n, stall, e_stall);
            end
            if (flush || e_stall || !if_id_valid) begin
                n_valid = 1'b0; n_ill = 1'b0; n_ctl = '0; n_npc = '0; n_rd1 = '0; n_rd2 = '0;
                n_imm = '0; n_rt = '0; n_rd = '0;
            end else begin
                dec     = mdecode(instr_in[31:26]);
                n_valid = 1'b1;
                n_ill   = dec[9];
                n_ctl   = dec[8:0];
                n_npc   = npc_in;
                n_rd1   = mread(rs);
                n_rd2   = mread(rt);
                n_imm   = 32'($signed(instr_in[15:0]));
                n_rt    = rt;
                n_rd    = instr_in[15:11];
            end
            step();
            if (wb_regwrite && wb_rd != 5'd0) mreg[wb_rd] = wb_data;
            e_valid = n_valid; e_ill = n_ill; e_ctl = n_ctl; e_npc = n_npc;
            e_rd1 = n_rd1; e_rd2 = n_rd2; e_imm = n_imm; e_rt = n_rt; e_rd = n_rd;
            checks++;
            if ({id_ex_valid, illegal} !== {e_valid, e_ill}) begin
                errors++; $display("FAIL rand_valid cyc %0d: valid=%b ill=%b want %b %b", n, id_ex_valid, illegal, e_valid, e_ill);
            end
            checks++;
            if ({ctl_ex, ctl_m, ctl_wb} !== e_ctl) begin
                errors++; $display("FAIL rand_ctl cyc %0d: got %b want %b", n, {ctl_ex, ctl_m, ctl_wb}, e_ctl);
            end
            checks++;
            if ({npc_out, rd1, rd2, imm_ext, rt_out, rd_out} !== {e_npc, e_rd1, e_rd2, e_imm, e_rt, e_rd}) begin
                errors++;
                $display("FAIL rand_data cyc %0d: npc=%h rd1=%h rd2=%h imm=%h rt=%0d rd=%0d want %h %h %h %h %0d %0d",
                         n, npc_out, rd1, rd2, imm_ext, rt_out, rd_out, e_npc, e_rd1, e_rd2, e_imm, e_rt, e_rd);
            end
            hold = e_stall;
        end
        drive_idle();
        step();
    endtask

    initial begin
        drive_idle();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        test_reset();
        test_wb_decode();
        test_bypass();
        test_load_use();
        test_flush_stall();
        test_signext_illegal();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
